edit_mem_read_count_mgr: RTL and testbench
==========================================

# edit_mem_read_count_mgr

Per-buffer read-count manager for the edit memory. It sits directly downstream of the edit-memory linked list. It loads the initial read count of every buffer from the linked list's read-count stream, then decrements that count on each per-port read-done event. When a buffer's count reaches zero, it returns the buffer pointer to the free-buffer pool.

## Interface
Parameters:
- BPTR_NBITS, `EM_BUF_PTR_NBITS: buffer pointer width; the count RAM depth is 2^BPTR_NBITS.
- RC_NBITS, `READ_COUNT_NBITS: read count width.
- SET_FIFO_DEPTH, 8: depth of the load-request FIFO.

Ports:
- clk  in  1  clock; the block has a single clock domain.
- rst  in  1  synchronous, active-high reset.
- read_count_valid  in  1  load request from the linked list; has no backpressure.
- read_count_port_id  in  `PORT_ID_NBITS  source port; carried through to free_buf_port_id.
- read_count_buf_ptr  in  BPTR_NBITS  buffer being loaded.
- read_count  in  RC_NBITS  initial number of reads owed on that buffer.
- rd_done_valid  in  1  one port has finished reading a buffer; has no backpressure.
- rd_done_buf_ptr  in  BPTR_NBITS  buffer that was read.
- free_buf_valid  out  1  one-cycle pulse: buffer is returned to the pool.
- free_buf_ptr  out  BPTR_NBITS  buffer being freed.
- free_buf_port_id  out  `PORT_ID_NBITS  port id captured at load time.
- underflow_err  out  1  sticky: a decrement arrived while the count was 0.
- set_ovf_err  out  1  sticky: a load request arrived while the load FIFO was full.

## Operation
- Storage:
  - count RAM, 1R1W, 1-cycle registered read, RC_NBITS wide, indexed by buffer pointer;
  - port-id RAM, same addressing.
  - Neither RAM is reset. A buffer's contents are valid only after it has been loaded.
- Load requests are written to a FIFO of SET_FIFO_DEPTH entries. Decrement events bypass the FIFO.
- Arbitration, one operation per cycle into the pipeline:
  - a decrement always wins;
  - a load is popped from the FIFO only in a cycle with no rd_done_valid.
- Load operation:
  - writes count = read_count and writes the port id;
  - if read_count == 0, frees the buffer immediately; the RAM then holds 0.
- Decrement operation:
  - reads the count c;
  - if c > 1, writes c-1 and does not free;
  - if c == 1, writes 0 and frees;
  - if c == 0, sets underflow_err, writes nothing and does not free.
- Ordering: the linked list guarantees that a buffer's load precedes its first decrement at the block inputs. The block preserves arbitration order per buffer.
- Hazards: back-to-back operations on the same pointer at 1- or 2-cycle spacing must see the results of all earlier operations. This requires full bypass from both the write stage and the registered write; stale RAM data is never used.
- Decrement arithmetic is RC_NBITS wide with no wrap. The c == 0 case never writes.
- If the FIFO is full and read_count_valid is asserted:
  - the request is dropped and set_ovf_err is set;
  - if the FIFO is popped in that same cycle, the push succeeds and no error is raised.
- Reset mid-operation:
  - clears all pipeline valids, the FIFO, free_buf_valid and both error flags;
  - any in-flight operation is lost;
  - RAM contents are retained but are treated as undefined.

## Timing
- Reset values:
  - free_buf_valid = 0, underflow_err = 0, set_ovf_err = 0;
  - free_buf_ptr and free_buf_port_id = 0.
- Pipeline, for an operation accepted into the pipeline in cycle T:
  - T: input registered;
  - T+1: RAM read;
  - T+2: data available, compute and write;
  - T+3: free_buf_valid / free_buf_ptr registered.
- A load issues from the FIFO one cycle after it is pushed, at the earliest. Its free therefore appears no earlier than 4 cycles after read_count_valid.
- Decrement-to-free latency is 3 cycles.
- underflow_err rises at T+3.
- Throughput: one operation per cycle sustained. At most one free pulse per cycle.

## Test plan
- Load ptr 5 with count 3, then decrement ptr 5 in three non-adjacent cycles:
  - free_buf_valid pulses exactly once, with ptr 5, 3 cycles after the third decrement;
  - free_buf_port_id equals the loaded port id.
- Load ptr 9 with count 0: free of ptr 9 appears 4 cycles after read_count_valid, with no decrements needed.
- Load ptr 2 with count 4, then decrement ptr 2 on four consecutive cycles (bypass check): exactly one free of ptr 2, 3 cycles after the 4th decrement; underflow_err stays 0.
- Decrement a loaded-then-freed ptr 2 once more: underflow_err = 1 at T+3, no free, and it stays 1 until reset.
- Hold rd_done_valid high for 12 cycles on distinct loaded pointers while pushing 9 loads:
  - loads stall, and set_ovf_err = 1 on the 9th push;
  - the 8 queued loads drain in order once decrements stop.
- Assert rst with 3 operations in flight: no free_buf_valid follows; errors and FIFO are cleared; a fresh load of count 1 plus one decrement frees normally.

Source files
------------

// File: rtl/edit_mem_read_count_mgr.sv
`default_nettype none

`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 6
`endif
`ifndef READ_COUNT_NBITS
`define READ_COUNT_NBITS 4
`endif
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 3
`endif

// +--------------------------------------------------------------------------+
// | Module   : edit_mem_read_count_mgr                                       |
// | Purpose  : per-buffer read counts; frees a buffer when its count drains  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module edit_mem_read_count_mgr #(
  parameter int BPTR_NBITS     = `EM_BUF_PTR_NBITS,
  parameter int RC_NBITS       = `READ_COUNT_NBITS,
  parameter int PORT_NBITS     = `PORT_ID_NBITS,
  parameter int SET_FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_count_valid,
  input  logic [PORT_NBITS-1:0] read_count_port_id,
  input  logic [BPTR_NBITS-1:0] read_count_buf_ptr,
  input  logic [RC_NBITS-1:0]   read_count,
  input  logic                  rd_done_valid,
  input  logic [BPTR_NBITS-1:0] rd_done_buf_ptr,
  output logic                  free_buf_valid,
  output logic [BPTR_NBITS-1:0] free_buf_ptr,
  output logic [PORT_NBITS-1:0] free_buf_port_id,
  output logic                  underflow_err,
  output logic                  set_ovf_err
);

  localparam int c_NBUF = 1 << BPTR_NBITS;
  localparam int c_FAW  = (SET_FIFO_DEPTH > 1) ? $clog2(SET_FIFO_DEPTH) : 1;
  localparam int c_FCW  = $clog2(SET_FIFO_DEPTH + 1);
  localparam logic [c_FAW-1:0]    c_FA_LAST = c_FAW'(SET_FIFO_DEPTH - 1);
  localparam logic [c_FAW-1:0]    c_FA_ONE  = c_FAW'(1);
  localparam logic [c_FCW-1:0]    c_FC_FULL = c_FCW'(SET_FIFO_DEPTH);
  localparam logic [c_FCW-1:0]    c_FC_ONE  = c_FCW'(1);
  localparam logic [RC_NBITS-1:0] c_RC_ONE  = RC_NBITS'(1);

  // Load-request FIFO
  logic [BPTR_NBITS-1:0] r_fq_ptr  [SET_FIFO_DEPTH];
  logic [RC_NBITS-1:0]   r_fq_cnt  [SET_FIFO_DEPTH];
  logic [PORT_NBITS-1:0] r_fq_port [SET_FIFO_DEPTH];
  logic [c_FAW-1:0]      r_fq_wr;
  logic [c_FAW-1:0]      r_fq_rd;
  logic [c_FCW-1:0]      r_fq_level;
  logic                  w_fq_empty;
  logic                  w_fq_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf;

  assign w_fq_empty = (r_fq_level == '0);
  assign w_fq_full  = (r_fq_level == c_FC_FULL);
  assign w_pop      = !w_fq_empty && !rd_done_valid;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_push     = read_count_valid && (!w_fq_full || w_pop);
  assign w_ovf      = read_count_valid && w_fq_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fq_ptr[r_fq_wr]  <= read_count_buf_ptr;
      r_fq_cnt[r_fq_wr]  <= read_count;
      r_fq_port[r_fq_wr] <= read_count_port_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fq_wr    <= '0;
      r_fq_rd    <= '0;
      r_fq_level <= '0;
    end else begin
      if (w_push) r_fq_wr <= (r_fq_wr == c_FA_LAST) ? '0 : r_fq_wr + c_FA_ONE;
      if (w_pop)  r_fq_rd <= (r_fq_rd == c_FA_LAST) ? '0 : r_fq_rd + c_FA_ONE;
      if (w_push && !w_pop)      r_fq_level <= r_fq_level + c_FC_ONE;
      else if (!w_push && w_pop) r_fq_level <= r_fq_level - c_FC_ONE;
    end
  end

  // Pipeline stage 0: accepted operation, RAM read address
  logic                  r_s0_valid;
  logic                  r_s0_is_load;
  logic [BPTR_NBITS-1:0] r_s0_ptr;
  logic [RC_NBITS-1:0]   r_s0_cnt;
  logic [PORT_NBITS-1:0] r_s0_port;
  // Pipeline stage 1: RAM data present, compute and write
  logic                  r_s1_valid;
  logic                  r_s1_is_load;
  logic [BPTR_NBITS-1:0] r_s1_ptr;
  logic [RC_NBITS-1:0]   r_s1_cnt;
  logic [PORT_NBITS-1:0] r_s1_port;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s0_valid <= rd_done_valid || w_pop;
      r_s1_valid <= r_s0_valid;
    end
  end

  always_ff @(posedge clk) begin
    r_s0_is_load <= !rd_done_valid;
    r_s0_ptr     <= rd_done_valid ? rd_done_buf_ptr : r_fq_ptr[r_fq_rd];
    r_s0_cnt     <= r_fq_cnt[r_fq_rd];
    r_s0_port    <= r_fq_port[r_fq_rd];
    r_s1_is_load <= r_s0_is_load;
    r_s1_ptr     <= r_s0_ptr;
    r_s1_cnt     <= r_s0_cnt;
    r_s1_port    <= r_s0_port;
  end

  // Count and port-id RAMs, registered read
  logic [RC_NBITS-1:0]   r_cnt_mem  [c_NBUF];
  logic [PORT_NBITS-1:0] r_port_mem [c_NBUF];
  logic [RC_NBITS-1:0]   r_ram_cnt;
  logic [PORT_NBITS-1:0] r_ram_port;
  logic                  w_wr_en;
  logic [RC_NBITS-1:0]   w_wr_cnt;
  logic [PORT_NBITS-1:0] w_wr_port;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_cnt_mem[r_s1_ptr]  <= w_wr_cnt;
      r_port_mem[r_s1_ptr] <= w_wr_port;
    end
    r_ram_cnt  <= r_cnt_mem[r_s0_ptr];
    r_ram_port <= r_port_mem[r_s0_ptr];
  end

  // The write landing on the same edge as the read is invisible to it, so
  // the previous write is held here and forwarded on a pointer match.
  logic                  r_wb_valid;
  logic [BPTR_NBITS-1:0] r_wb_ptr;
  logic [RC_NBITS-1:0]   r_wb_cnt;
  logic [PORT_NBITS-1:0] r_wb_port;
  logic                  w_hit;
  logic [RC_NBITS-1:0]   w_cur_cnt;
  logic [PORT_NBITS-1:0] w_cur_port;
  logic                  w_free;
  logic                  w_uflow;

  assign w_hit      = r_wb_valid && (r_wb_ptr == r_s1_ptr);
  assign w_cur_cnt  = w_hit ? r_wb_cnt  : r_ram_cnt;
  assign w_cur_port = w_hit ? r_wb_port : r_ram_port;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_cnt  = r_s1_cnt;
    w_wr_port = w_cur_port;
    w_free    = 1'b0;
    w_uflow   = 1'b0;
    if (r_s1_valid) begin
      if (r_s1_is_load) begin
        w_wr_en   = 1'b1;
        w_wr_cnt  = r_s1_cnt;
        w_wr_port = r_s1_port;
        w_free    = (r_s1_cnt == '0);
      end else if (w_cur_cnt == '0) begin
        w_uflow = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_wr_cnt = w_cur_cnt - c_RC_ONE;
        w_free   = (w_cur_cnt == c_RC_ONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_wb_valid <= 1'b0;
    else     r_wb_valid <= w_wr_en;
    r_wb_ptr  <= r_s1_ptr;
    r_wb_cnt  <= w_wr_cnt;
    r_wb_port <= w_wr_port;
  end

  // Output and sticky error registers
  logic                  r_free_valid;
  logic [BPTR_NBITS-1:0] r_free_ptr;
  logic [PORT_NBITS-1:0] r_free_port;
  logic                  r_uflow_err;
  logic                  r_ovf_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free_valid <= 1'b0;
      r_free_ptr   <= '0;
      r_free_port  <= '0;
      r_uflow_err  <= 1'b0;
      r_ovf_err    <= 1'b0;
    end else begin
      r_free_valid <= w_free;
      if (w_free) begin
        r_free_ptr  <= r_s1_ptr;
        r_free_port <= w_wr_port;
      end
      r_uflow_err <= r_uflow_err | w_uflow;
      r_ovf_err   <= r_ovf_err | w_ovf;
    end
  end

  assign free_buf_valid   = r_free_valid;
  assign free_buf_ptr     = r_free_ptr;
  assign free_buf_port_id = r_free_port;
  assign underflow_err    = r_uflow_err;
  assign set_ovf_err      = r_ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_edit_mem_read_count_mgr.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module   : tb_edit_mem_read_count_mgr                                    |
// | Purpose  : self-checking bench for edit_mem_read_count_mgr               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_edit_mem_read_count_mgr;
  localparam int BP = 6, RC = 4, PN = 3, D = 8, NBUF = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_count_valid;
  logic [PN-1:0] read_count_port_id;
  logic [BP-1:0] read_count_buf_ptr;
  logic [RC-1:0] read_count;
  logic          rd_done_valid;
  logic [BP-1:0] rd_done_buf_ptr;
  logic          free_buf_valid;
  logic [BP-1:0] free_buf_ptr;
  logic [PN-1:0] free_buf_port_id;
  logic          underflow_err;
  logic          set_ovf_err;

  edit_mem_read_count_mgr #(
    .BPTR_NBITS(BP), .RC_NBITS(RC), .PORT_NBITS(PN), .SET_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .read_count_valid(read_count_valid), .read_count_port_id(read_count_port_id),
    .read_count_buf_ptr(read_count_buf_ptr), .read_count(read_count),
    .rd_done_valid(rd_done_valid), .rd_done_buf_ptr(rd_done_buf_ptr),
    .free_buf_valid(free_buf_valid), .free_buf_ptr(free_buf_ptr),
    .free_buf_port_id(free_buf_port_id), .underflow_err(underflow_err),
    .set_ovf_err(set_ovf_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-buffer counts applied in arbitration order
  typedef struct {int ptr; int cnt; int port;} ld_t;
  typedef struct {bit v; int ptr; int port;} fr_t;
  int  m_cnt   [NBUF];
  int  m_port  [NBUF];
  bit  m_known [NBUF];
  ld_t m_q [$];
  fr_t m_d0, m_d1, m_out;
  bit  m_u0, m_u1, m_uf, m_ovf;
  fr_t seen [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rcv, input int rport, input int rptr, input int rcnt,
                      input bit rdv, input int rdptr);
    fr_t nf;
    fr_t obs;
    ld_t ld;
    bit  nu;
    bit  pop;
    read_count_valid   = rcv;
    read_count_port_id = PN'(rport);
    read_count_buf_ptr = BP'(rptr);
    read_count         = RC'(rcnt);
    rd_done_valid      = rdv;
    rd_done_buf_ptr    = BP'(rdptr);
    nf  = '{1'b0, 0, 0};
    nu  = 1'b0;
    pop = (m_q.size() > 0) && !rdv;
    if (rdv) begin
      if (m_cnt[rdptr] == 0) nu = 1'b1;
      else begin
        m_cnt[rdptr]--;
        if (m_cnt[rdptr] == 0) nf = '{1'b1, rdptr, m_port[rdptr]};
      end
    end else if (pop) begin
      ld = m_q.pop_front();
      m_cnt[ld.ptr]   = ld.cnt;
      m_port[ld.ptr]  = ld.port;
      m_known[ld.ptr] = 1'b1;
      if (ld.cnt == 0) nf = '{1'b1, ld.ptr, ld.port};
    end
    if (rcv) begin
      if (m_q.size() < D) begin
        ld.ptr = rptr; ld.cnt = rcnt; ld.port = rport;
        m_q.push_back(ld);
      end else m_ovf = 1'b1;
    end
    // Frees and underflow appear three cycles after acceptance.
    m_out = m_d1; m_d1 = m_d0; m_d0 = nf;
    m_uf  = m_uf | m_u1; m_u1 = m_u0; m_u0 = nu;
    @(posedge clk); #1;
    chk("free_valid", free_buf_valid, m_out.v);
    if (m_out.v) begin
      chk("free_ptr", free_buf_ptr, m_out.ptr);
      chk("free_port", free_buf_port_id, m_out.port);
    end
    chk("underflow_err", underflow_err, m_uf);
    chk("set_ovf_err", set_ovf_err, m_ovf);
    if (free_buf_valid) begin
      obs = '{1'b1, int'(free_buf_ptr), int'(free_buf_port_id)};
      seen.push_back(obs);
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    read_count_valid = 1'b0;
    rd_done_valid    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_q.delete();
    m_d0 = '{1'b0, 0, 0}; m_d1 = '{1'b0, 0, 0};
    m_u0 = 1'b0; m_u1 = 1'b0; m_uf = 1'b0; m_ovf = 1'b0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    chk("rst_free_valid", free_buf_valid, 0);
    chk("rst_free_ptr", free_buf_ptr, 0);
    chk("rst_free_port", free_buf_port_id, 0);
    chk("rst_underflow", underflow_err, 0);
    chk("rst_set_ovf", set_ovf_err, 0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit rcv; int rport; int rptr; int rcnt; bit rdv; int rdptr;
    bit efv; int eptr; int eport;
  } vec_t;
  vec_t tbl [13];

  bit rcv, rdv;
  int rdp, p;

  initial begin
    rst = 1'b1;
    read_count_valid = 1'b0; read_count_port_id = '0; read_count_buf_ptr = '0;
    read_count = '0; rd_done_valid = 1'b0; rd_done_buf_ptr = '0;
    do_reset();

    // Expected outputs are those visible after each vector's clock edge.
    tbl[0]  = '{1'b1, 2, 5, 3, 1'b0, 0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 0, 0, 0, 1'b1, 5, 1'b0, 0, 0};
    tbl[4]  = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0};
    tbl[5]  = '{1'b0, 0, 0, 0, 1'b1, 5, 1'b0, 0, 0};
    tbl[6]  = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0};
    tbl[7]  = '{1'b0, 0, 0, 0, 1'b1, 5, 1'b0, 0, 0};
    tbl[8]  = '{1'b1, 6, 9, 0, 1'b0, 0, 1'b0, 0, 0};
    tbl[9]  = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 5, 2};
    tbl[10] = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0};
    tbl[11] = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 9, 6};
    tbl[12] = '{1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rcv, tbl[i].rport, tbl[i].rptr, tbl[i].rcnt, tbl[i].rdv, tbl[i].rdptr);
      chk("tbl_free_valid", free_buf_valid, tbl[i].efv);
      if (tbl[i].efv) begin
        chk("tbl_free_ptr", free_buf_ptr, tbl[i].eptr);
        chk("tbl_free_port", free_buf_port_id, tbl[i].eport);
      end
    end

    // Four back-to-back decrements on one pointer
    step(1'b1, 1, 2, 4, 1'b0, 0);
    idle(); idle();
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, 1'b1, 2);
    idle();
    chk("bypass_no_early_free", free_buf_valid, 0);
    idle();
    chk("bypass_free_valid", free_buf_valid, 1);
    chk("bypass_free_ptr", free_buf_ptr, 2);
    chk("bypass_no_underflow", underflow_err, 0);

    // Decrement of an already-freed buffer
    step(1'b0, 0, 0, 0, 1'b1, 2);
    idle();
    chk("uflow_not_yet", underflow_err, 0);
    idle();
    chk("uflow_set", underflow_err, 1);
    chk("uflow_no_free", free_buf_valid, 0);
    repeat (5) idle();
    chk("uflow_sticky", underflow_err, 1);

    // Load FIFO overflow while decrements hold off every pop
    for (int i = 0; i < 12; i++) step(1'b1, i % 8, 20 + i, 2, 1'b0, 0);
    repeat (3) idle();
    for (int i = 0; i < 12; i++) begin
      step(i < 9, i, 40 + i, 0, 1'b1, 20 + i);
      if (i == 7) chk("ovf_not_on_8th", set_ovf_err, 0);
      if (i == 8) chk("ovf_on_9th", set_ovf_err, 1);
    end
    seen.delete();
    repeat (12) idle();
    chk("drain_count", seen.size(), 8);
    for (int j = 0; j < 8 && j < seen.size(); j++) begin
      chk("drain_ptr", seen[j].ptr, 40 + j);
      chk("drain_port", seen[j].port, j);
    end

    // Reset with operations in flight
    step(1'b1, 3, 7, 1, 1'b0, 0);
    step(1'b1, 4, 8, 1, 1'b0, 0);
    repeat (3) idle();
    step(1'b0, 0, 0, 0, 1'b1, 7);
    step(1'b1, 5, 11, 2, 1'b1, 8);
    do_reset();
    seen.delete();
    repeat (6) idle();
    chk("rst_no_free", seen.size(), 0);
    step(1'b1, 6, 7, 1, 1'b0, 0);
    idle(); idle();
    step(1'b0, 0, 0, 0, 1'b1, 7);
    idle(); idle();
    chk("post_rst_free_valid", free_buf_valid, 1);
    chk("post_rst_free_ptr", free_buf_ptr, 7);
    chk("post_rst_free_port", free_buf_port_id, 6);

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rcv = ($urandom_range(0, 99) < 35);
      rdv = 1'b0;
      rdp = 0;
      if ($urandom_range(0, 99) < 45) begin
        for (int t = 0; t < 8; t++) begin
          p = $urandom_range(0, NBUF - 1);
          if (m_known[p] && (m_cnt[p] > 0 || $urandom_range(0, 19) == 0)) begin
            rdv = 1'b1;
            rdp = p;
            break;
          end
        end
      end
      step(rcv, $urandom_range(0, 7), $urandom_range(0, NBUF - 1), $urandom_range(0, 3), rdv, rdp);
    end
    repeat (12) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
